// File: rtl/idiv_pkg.sv
// Shared types and control encodings for the fixed-latency integer divider.
package idiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam logic IDIV_OP_DIVU = 1'b0;
    localparam logic IDIV_OP_DIV  = 1'b1;

    // Quotient/shift register select
    localparam logic [2:0] QSEL_HOLD  = 3'd0;
    localparam logic [2:0] QSEL_LOAD  = 3'd1;
    localparam logic [2:0] QSEL_SHIFT = 3'd2;
    localparam logic [2:0] QSEL_FIX   = 3'd3;
    localparam logic [2:0] QSEL_ONES  = 3'd4;

    // Remainder register select
    localparam logic [2:0] RSEL_HOLD  = 3'd0;
    localparam logic [2:0] RSEL_CLEAR = 3'd1;
    localparam logic [2:0] RSEL_SHIFT = 3'd2;
    localparam logic [2:0] RSEL_TRIAL = 3'd3;
    localparam logic [2:0] RSEL_FIX   = 3'd4;

endpackage

// File: rtl/idiv_int_div_fixed_lat_dpath.sv
// Divider datapath: operand magnitudes, restoring shift-subtract step and sign fix-up.
module idiv_int_div_fixed_lat_dpath
    import idiv_pkg::*;
#(
    parameter int unsigned NBITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2*NBITS:0]   i_recv_msg,
    input  logic [2:0]         i_qsel,
    input  logic [2:0]         i_rsel,
    output logic               o_trial_neg,
    output logic               o_div0,
    output logic [NBITS-1:0]   o_quo,
    output logic [NBITS-1:0]   o_rem
);

    logic [NBITS-1:0] r_quo;
    logic [NBITS:0]   r_rem;
    logic [NBITS-1:0] r_div;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_div0;

    logic             w_op;
    logic [NBITS-1:0] w_a;
    logic [NBITS-1:0] w_b;
    logic [NBITS-1:0] w_amag;
    logic [NBITS-1:0] w_bmag;
    logic [NBITS+1:0] w_rem_sh;
    logic [NBITS+1:0] w_trial;

    assign w_op = i_recv_msg[2*NBITS];
    assign w_a  = i_recv_msg[2*NBITS-1:NBITS];
    assign w_b  = i_recv_msg[NBITS-1:0];

    // Unsigned reinterpretation makes |-2^(N-1)| = 2^(N-1) without overflow
    assign w_amag = (w_op == IDIV_OP_DIV && w_a[NBITS-1]) ? (~w_a + 1'b1) : w_a;
    assign w_bmag = (w_op == IDIV_OP_DIV && w_b[NBITS-1]) ? (~w_b + 1'b1) : w_b;

    // One guard bit above the remainder register keeps the trial sign unambiguous
    assign w_rem_sh    = {r_rem, r_quo[NBITS-1]};
    assign w_trial     = w_rem_sh - {2'b00, r_div};
    assign o_trial_neg = w_trial[NBITS+1];

    assign o_div0 = r_div0;
    assign o_quo  = r_quo;
    assign o_rem  = r_rem[NBITS-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_quo  <= '0;
            r_div  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_div0 <= 1'b0;
        end else begin
            case (i_qsel)
                QSEL_LOAD: begin
                    r_quo  <= w_amag;
                    r_div  <= w_bmag;
                    r_qneg <= w_op & (w_a[NBITS-1] ^ w_b[NBITS-1]);
                    r_rneg <= w_op & w_a[NBITS-1];
                    r_div0 <= (w_b == '0);
                end
                QSEL_SHIFT: r_quo <= {r_quo[NBITS-2:0], (i_rsel == RSEL_TRIAL)};
                QSEL_FIX:   r_quo <= r_qneg ? (~r_quo + 1'b1) : r_quo;
                QSEL_ONES:  r_quo <= '1;
                default:    r_quo <= r_quo;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem <= '0;
        end else begin
            case (i_rsel)
                RSEL_CLEAR: r_rem <= '0;
                RSEL_SHIFT: r_rem <= w_rem_sh[NBITS:0];
                RSEL_TRIAL: r_rem <= w_trial[NBITS:0];
                RSEL_FIX:   r_rem <= {1'b0, (r_rneg ? (~r_rem[NBITS-1:0] + 1'b1) : r_rem[NBITS-1:0])};
                default:    r_rem <= r_rem;
            endcase
        end
    end

endmodule

// File: rtl/idiv_int_div_fixed_lat.sv
// Fixed-latency restoring integer divider (RISC-V DIV/DIVU/REM/REMU) with val/rdy streams.
module idiv_int_div_fixed_lat
    import idiv_pkg::*;
#(
    parameter int unsigned NBITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               recv_val,
    output logic               recv_rdy,
    input  logic [2*NBITS:0]   recv_msg,
    output logic               send_val,
    input  logic               send_rdy,
    output logic [2*NBITS-1:0] send_msg
);

    localparam int unsigned CW = $clog2(NBITS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic [2:0]       w_qsel;
    logic [2:0]       w_rsel;
    logic             w_trial_neg;
    logic             w_div0;
    logic [NBITS-1:0] w_quo;
    logic [NBITS-1:0] w_rem;

    idiv_int_div_fixed_lat_dpath #(
        .NBITS (NBITS)
    ) u_dpath (
        .clk         (clk),
        .reset       (reset),
        .i_recv_msg  (recv_msg),
        .i_qsel      (w_qsel),
        .i_rsel      (w_rsel),
        .o_trial_neg (w_trial_neg),
        .o_div0      (w_div0),
        .o_quo       (w_quo),
        .o_rem       (w_rem)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_qsel      = QSEL_HOLD;
        w_rsel      = RSEL_HOLD;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (recv_val && recv_rdy) begin
                    w_state_nxt = CALC;
                    w_qsel      = QSEL_LOAD;
                    w_rsel      = RSEL_CLEAR;
                    w_cnt_clr   = 1'b1;
                end
            end
            CALC: begin
                w_qsel    = QSEL_SHIFT;
                w_rsel    = w_trial_neg ? RSEL_SHIFT : RSEL_TRIAL;
                w_cnt_inc = 1'b1;
                if (r_cnt == CW'(NBITS - 1)) w_state_nxt = FIX;
            end
            FIX: begin
                // div0 remainder falls out of the loop as |a|, so only the quotient is overridden
                w_qsel      = w_div0 ? QSEL_ONES : QSEL_FIX;
                w_rsel      = RSEL_FIX;
                w_state_nxt = DONE;
            end
            DONE: begin
                if (send_rdy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign recv_rdy = reset && (r_state == IDLE);
    assign send_val = (r_state == DONE);
    assign send_msg = send_val ? {w_quo, w_rem} : '0;

endmodule

// File: tb/tb_idiv_int_div_fixed_lat.sv
// Directed testbench for idiv_int_div_fixed_lat (NBITS = 32).
module tb_idiv_int_div_fixed_lat;
    import idiv_pkg::*;

    localparam int N = 32;
    localparam int EXP_LAT = 34;

    logic           clk;
    logic           reset;
    logic           recv_val;
    logic           recv_rdy;
    logic [2*N:0]   recv_msg;
    logic           send_val;
    logic           send_rdy;
    logic [2*N-1:0] send_msg;

    int checks;
    int errors;

    idiv_int_div_fixed_lat #(
        .NBITS (N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .recv_msg (recv_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .send_msg (send_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full transaction: request, latency + result check, optional backpressure, send handshake.
    // lat is the cycle index of first send_val, the acceptance cycle being cycle 0.
    task automatic do_txn(input logic op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] exp, input string name,
                          input int hold, input bit pulse, output int wait_cycles);
        int lat;
        logic [2*N-1:0] cap;
        lat = 0;
        wait_cycles = 0;
        @(negedge clk);
        recv_val = 1'b1;
        recv_msg = {op, a, b};
        while (!recv_rdy && wait_cycles < 100) begin
            @(negedge clk);
            wait_cycles++;
        end
        checks++;
        if (recv_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: recv_rdy never rose (got %b, want 1)", name, recv_rdy);
            recv_val = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        recv_val = 1'b0;
        recv_msg = {IDIV_OP_DIVU, 32'hDEAD_BEEF, 32'h0000_0001};
        for (int i = 1; i <= 100; i++) begin
            if (pulse && i == 3) recv_val = 1'b1;
            if (pulse && i == 7) recv_val = 1'b0;
            if (pulse && i >= 3 && i <= 6) begin
                checks++;
                if (recv_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_rdy: cycle %0d recv_rdy=%b want 0", name, i, recv_rdy);
                end
            end
            @(posedge clk);
            #1;
            if (send_val === 1'b1) begin
                lat = i + 1;
                break;
            end
        end
        recv_val = 1'b0;
        checks++;
        if (lat !== EXP_LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, EXP_LAT);
        end
        checks++;
        if (send_msg !== exp) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, send_msg, exp);
        end
        cap = send_msg;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            checks++;
            if (send_val !== 1'b1 || send_msg !== cap || recv_rdy !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: val=%b msg=%h rdy=%b want val=1 msg=%h rdy=0",
                         name, h, send_val, send_msg, recv_rdy, cap);
            end
        end
        send_rdy = 1'b1;
        @(posedge clk);
        #1;
        send_rdy = 1'b0;
        checks++;
        if (send_val !== 1'b0 || send_msg !== '0 || recv_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s after_send: val=%b msg=%h rdy=%b want val=0 msg=0 rdy=1",
                     name, send_val, send_msg, recv_rdy);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        recv_val = 1'b1;
        recv_msg = {IDIV_OP_DIVU, 32'd10, 32'd2};
        send_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (recv_rdy !== 1'b0 || send_val !== 1'b0 || send_msg !== '0) begin
            errors++;
            $display("FAIL reset_hold: rdy=%b val=%b msg=%h want 0 0 0", recv_rdy, send_val, send_msg);
        end
        recv_val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (recv_rdy !== 1'b1 || send_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b val=%b want 1 0", recv_rdy, send_val);
        end
    endtask

    task automatic test_unsigned();
        int w;
        do_txn(IDIV_OP_DIVU, 32'd100, 32'd7, {32'h0000000E, 32'h00000002}, "divu_100_7", 0, 1'b0, w);
        do_txn(IDIV_OP_DIVU, 32'hFFFFFFFF, 32'd1, {32'hFFFFFFFF, 32'h0}, "divu_max_1", 0, 1'b0, w);
    endtask

    task automatic test_signed();
        int w;
        do_txn(IDIV_OP_DIV, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFF2, 32'hFFFFFFFE}, "div_m100_7", 0, 1'b0, w);
        do_txn(IDIV_OP_DIV, 32'd100, 32'hFFFFFFF9, {32'hFFFFFFF2, 32'h00000002}, "div_100_m7", 0, 1'b0, w);
        do_txn(IDIV_OP_DIV, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, "div_overflow", 0, 1'b0, w);
    endtask

    task automatic test_div0();
        int w;
        do_txn(IDIV_OP_DIVU, 32'd5, 32'd0, {32'hFFFFFFFF, 32'h00000005}, "divu_by0", 0, 1'b0, w);
        do_txn(IDIV_OP_DIV, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFF, 32'hFFFFFFFB}, "div_by0", 0, 1'b0, w);
    endtask

    task automatic test_backpressure();
        int w;
        do_txn(IDIV_OP_DIVU, 32'd1000, 32'd33, {32'h0000001E, 32'h0000000A}, "backpressure", 5, 1'b1, w);
    endtask

    task automatic test_back_to_back();
        int w;
        do_txn(IDIV_OP_DIVU, 32'd7, 32'd2, {32'h00000003, 32'h00000001}, "b2b_first", 0, 1'b0, w);
        do_txn(IDIV_OP_DIV, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFD, 32'hFFFFFFFF}, "b2b_second", 0, 1'b0, w);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL b2b_accept: waited %0d cycles want 0", w);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        @(negedge clk);
        recv_val = 1'b1;
        recv_msg = {IDIV_OP_DIVU, 32'd100, 32'd7};
        @(posedge clk);
        #1;
        recv_val = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (recv_rdy !== 1'b0 || send_val !== 1'b0 || send_msg !== '0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b val=%b msg=%h want 0 0 0", recv_rdy, send_val, send_msg);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (recv_rdy !== 1'b1 || send_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: rdy=%b val=%b want 1 0", recv_rdy, send_val);
        end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (send_val !== 1'b0 || recv_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_stale: val=%b rdy=%b want 0 1", send_val, recv_rdy);
        end
        do_txn(IDIV_OP_DIVU, 32'd9, 32'd3, {32'h00000003, 32'h0}, "after_reset_9_3", 0, 1'b0, w);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        recv_val = 1'b0;
        recv_msg = '0;
        send_rdy = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div0();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
